// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the bus round-robin scheduler.
// State encoding, id constants and destination-field extraction.
package bus_sched_pkg;

  localparam int ID_W = 8;
  localparam int MAX_W = 1024;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    DELIVER
  } state_t;

  // Destination id lives in the top byte of a packet of width sz.
  function automatic logic [ID_W-1:0] dest_of(
    input logic [MAX_W-1:0] w,
    input int sz
  );
    return w[sz-1 -: ID_W];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester at or after ptr, wrapping at drvrs.
module rr_pick
  import bus_sched_pkg::*;
#(
  parameter int drvrs = 8
) (
  input  logic [drvrs-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any_req
);

  logic [ID_W:0] w_j;

  // Scan downwards so the nearest requester to ptr wins last.
  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    w_j     = '0;
    for (int i = drvrs - 1; i >= 0; i--) begin
      w_j = {1'b0, ptr} + 9'(i);
      if (w_j >= 9'(drvrs)) w_j = w_j - 9'(drvrs);
      if (1'(req >> w_j)) begin
        gnt_idx = w_j[ID_W-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler moving one packet at a time from driver
// FIFOs onto a shared bus with unicast, broadcast and drop handling.
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int drvrs   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  input  logic [drvrs-1:0]         full,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic [ID_W-1:0]          err_cnt
);

  localparam logic [drvrs-1:0] ONE  = drvrs'(1);
  localparam logic [ID_W-1:0]  NDRV = ID_W'(drvrs);

  state_t             r_state, w_state;
  logic [ID_W-1:0]    r_ptr, w_ptr;
  logic [ID_W-1:0]    r_grant, w_grant;
  logic [pckg_sz-1:0] r_pkt, w_pkt;
  logic [drvrs-1:0]   r_pop, w_pop;
  logic [drvrs-1:0]   r_push, w_push;
  logic [pckg_sz-1:0] r_dpush, w_dpush;
  logic [ID_W-1:0]    r_err, w_err;
  logic               r_busy;

  int                 w_base;
  logic [pckg_sz-1:0] w_head, w_word;
  logic [MAX_W-1:0]   w_ext;
  logic [ID_W-1:0]    w_dst, w_gnt, w_nxt_ptr;
  logic               w_any, w_bcast, w_uni, w_ok;
  logic [drvrs-1:0]   w_src, w_mask;

  rr_pick #(.drvrs(drvrs)) u_pick (
    .req     (pndng),
    .ptr     (r_ptr),
    .gnt_idx (w_gnt),
    .any_req (w_any)
  );

  assign w_base = int'(r_grant) * pckg_sz;
  assign w_head = D_pop[w_base +: pckg_sz];

  // Classify the packet: live FIFO head in POP, latched copy later.
  always_comb begin
    w_word = (r_state == POP) ? w_head : r_pkt;
    w_ext  = '0;
    w_ext[pckg_sz-1:0] = w_word;
    w_dst   = dest_of(w_ext, pckg_sz);
    w_src   = ONE << r_grant;
    w_bcast = (w_dst == BCAST_ID);
    w_uni   = (w_dst < NDRV) && (w_dst != r_grant);
    w_mask  = w_bcast ? ~w_src : (w_uni ? (ONE << w_dst) : '0);
    w_ok    = (w_bcast || w_uni) && ((full & w_mask) == '0);
    w_nxt_ptr = (r_grant == NDRV - 8'd1) ? '0 : r_grant + 8'd1;
  end

  // Next-state and next-output logic; strobes default low.
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_grant = r_grant;
    w_pkt   = r_pkt;
    w_pop   = '0;
    w_push  = '0;
    w_dpush = r_dpush;
    w_err   = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state = POP;
          w_grant = w_gnt;
          w_pop   = ONE << w_gnt;
        end
      end
      POP: begin
        w_state = DELIVER;
        w_pkt   = w_head;
        if (w_ok) begin
          w_push  = w_mask;
          w_dpush = w_head;
        end
      end
      DELIVER: begin
        if (r_push != '0) begin
          w_state = IDLE;
          w_ptr   = w_nxt_ptr;
        end else if (!(w_bcast || w_uni)) begin
          w_state = IDLE;
          w_ptr   = w_nxt_ptr;
          w_err   = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
        end else if (w_ok) begin
          w_push  = w_mask;
          w_dpush = r_pkt;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_pkt   <= '0;
      r_pop   <= '0;
      r_push  <= '0;
      r_dpush <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_grant <= w_grant;
      r_pkt   <= w_pkt;
      r_pop   <= w_pop;
      r_push  <= w_push;
      r_dpush <= w_dpush;
      r_err   <= w_err;
      r_busy  <= (w_state != IDLE);
    end
  end

  assign pop      = r_pop;
  assign push     = r_push;
  assign D_push   = r_dpush;
  assign grant_id = r_grant;
  assign busy     = r_busy;
  assign err_cnt  = r_err;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed self-checking bench for bus_rr_scheduler.
// Inputs change and outputs are checked on the falling edge.
module tb_bus_rr_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   pndng = '0;
  logic [127:0] D_pop = '0;
  logic [7:0]   pop;
  logic [7:0]   full = '0;
  logic [7:0]   push;
  logic [15:0]  D_push;
  logic [7:0]   grant_id;
  logic         busy;
  logic [7:0]   err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] seen;

  bus_rr_scheduler #(.pckg_sz(16), .drvrs(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .full     (full),
    .push     (push),
    .D_push   (D_push),
    .grant_id (grant_id),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int d, input logic [15:0] w);
    D_pop[d*16 +: 16] = w;
  endtask

  initial begin
    // reset state
    step(2);
    chk("rst_pop", pop, 0);
    chk("rst_push", push, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", grant_id, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_dpush", D_push, 0);
    reset = 1'b1;
    step();

    // basic unicast 2 -> 5
    wr(2, 16'h05AB);
    pndng = 8'b0000_0100;
    step();
    chk("u_pop", pop, 8'h04);
    chk("u_gnt", grant_id, 2);
    chk("u_busy1", busy, 1);
    chk("u_push0", push, 0);
    pndng = '0;
    step();
    chk("u_push", push, 8'h20);
    chk("u_dpush", D_push, 16'h05AB);
    chk("u_busy2", busy, 1);
    chk("u_pop0", pop, 0);
    step();
    chk("u_push_off", push, 0);
    chk("u_busy_off", busy, 0);
    chk("u_dhold", D_push, 16'h05AB);

    // full rotation after a fresh reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int d = 0; d < 8; d++)
      wr(d, {5'd0, 3'((d + 1) % 8), 4'hA, 4'(d)});
    pndng = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("rr_gnt", grant_id, k % 8);
      chk("rr_pop", pop, 8'h01 << (k % 8));
      step();
      chk("rr_push", push, 8'h01 << ((k + 1) % 8));
      chk("rr_data", D_push, {5'd0, 3'((k + 1) % 8), 4'hA, 4'(k % 8)});
      step();
      chk("rr_idle", busy, 0);
    end
    pndng = '0;

    // broadcast from driver 3
    wr(3, 16'hFF33);
    pndng = 8'b0000_1000;
    step();
    chk("b_pop", pop, 8'h08);
    pndng = '0;
    step();
    chk("b_push", push, 8'hF7);
    chk("b_data", D_push, 16'hFF33);
    step();
    chk("b_off", push, 0);

    // unicast 1 -> 6 held off by full[6]; pointer wraps to 1
    wr(1, 16'h06C1);
    wr(0, 16'h0300);
    full = 8'h40;
    pndng = 8'b0000_0010;
    step();
    chk("f_pop", pop, 8'h02);
    chk("f_gnt", grant_id, 1);
    pndng = 8'b0000_0001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("f_hold", push, 0);
      chk("f_nopop", pop, 0);
      chk("f_gnt_hold", grant_id, 1);
    end
    step();
    full = '0;
    step();
    chk("f_push", push, 8'h40);
    chk("f_data", D_push, 16'h06C1);
    step();
    chk("f_idle", busy, 0);
    step();
    chk("f_next_gnt", grant_id, 0);
    chk("f_next_pop", pop, 8'h01);
    pndng = '0;
    step();
    chk("f_next_push", push, 8'h08);
    step();

    // invalid destinations
    wr(1, 16'h0911);
    pndng = 8'b0000_0010;
    step();
    chk("i_pop", pop, 8'h02);
    pndng = '0;
    step();
    chk("i_push", push, 0);
    chk("i_err0", err_cnt, 0);
    step();
    chk("i_err1", err_cnt, 1);
    chk("i_busy", busy, 0);
    wr(2, 16'h0222);
    pndng = 8'b0000_0100;
    step();
    chk("s_pop", pop, 8'h04);
    pndng = '0;
    step();
    chk("s_push", push, 0);
    step();
    chk("s_err2", err_cnt, 2);

    // saturation
    wr(4, 16'h8044);
    pndng = 8'b0001_0000;
    seen = '0;
    for (int k = 0; k < 3 * 298; k++) begin
      step();
      seen |= push;
    end
    pndng = '0;
    chk("sat_nopush", seen, 0);
    chk("sat_err", err_cnt, 255);
    step(2);

    // reset mid-DELIVER
    wr(5, 16'h0155);
    full = 8'h02;
    pndng = 8'b0010_0000;
    step();
    chk("r_pop", pop, 8'h20);
    pndng = '0;
    step();
    chk("r_wait", push, 0);
    #2 reset = 1'b0;
    #1;
    chk("r_pop0", pop, 0);
    chk("r_push0", push, 0);
    chk("r_busy0", busy, 0);
    chk("r_gnt0", grant_id, 0);
    chk("r_err0", err_cnt, 0);
    chk("r_d0", D_push, 0);
    full = '0;
    wr(1, 16'h0311);
    pndng = 8'b0100_0110;
    step(2);
    reset = 1'b1;
    chk("r_rel_push", push, 0);
    step();
    chk("r_gnt", grant_id, 1);
    chk("r_pop1", pop, 8'h02);
    chk("r_nopush", push, 0);
    pndng = '0;
    step();
    chk("r_push", push, 8'h08);
    chk("r_data", D_push, 16'h0311);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
